// File: rtl/axi_id_remap_pkg.sv
// Shared width helpers for the AXI ID remapper and its in-flight ID tables.
package axi_id_remap_pkg;

    // Index width is kept at least 1 so a single-entry table still has a port.
    function automatic int unsigned idx_width(input int unsigned n_entries);
        return (n_entries > 1) ? $clog2(n_entries) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/axi_id_remap_table.sv
// One direction's table of in-flight unique IDs: lookup/allocate on requests,
// release on responses, and reverse lookup of the stored slave ID.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned ID_W      = 8,
    parameter int unsigned RSP_IDX_W = 3,
    parameter int unsigned N_ENTRIES = 4,
    parameter int unsigned MAX_TXNS  = 4,
    localparam int unsigned IDX_W    = idx_width(N_ENTRIES)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ID_W-1:0]      req_id,
    input  logic                 req_hs,
    output logic [IDX_W-1:0]     sel_idx,
    output logic                 stall,
    input  logic [RSP_IDX_W-1:0] rsp_idx,
    input  logic                 rsp_hs,
    output logic [ID_W-1:0]      rsp_slv_id
);

    localparam int unsigned     CNT_W    = cnt_width(MAX_TXNS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_TXNS);

    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t tbl [N_ENTRIES];

    logic                 hit, hit_full, free_found, rsp_ok;
    logic [IDX_W-1:0]     hit_idx, free_idx;
    logic [N_ENTRIES-1:0] inc, dec;

    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        hit        = 1'b0;
        hit_full   = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        // Scan downwards so the lowest free index is the one left standing.
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!tbl[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (tbl[i].valid && tbl[i].id == req_id) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(i);
                hit_full = (tbl[i].cnt == CNT_FULL);
            end
        end
        stall   = hit ? hit_full : !free_found;
        sel_idx = hit ? hit_idx : free_idx;
    end

    // Out-of-range or unallocated response indices return ID 0 and touch nothing.
    always_comb begin
        rsp_ok     = 1'b0;
        rsp_slv_id = '0;
        inc        = '0;
        dec        = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (int'(rsp_idx) == i && tbl[i].valid) begin
                rsp_ok     = 1'b1;
                rsp_slv_id = tbl[i].id;
                dec[i]     = rsp_hs;
            end
            inc[i] = req_hs && (sel_idx == IDX_W'(i));
        end
    end

    // NOTE: the table is a handful of flops, so every field is reset rather
    // than only the valid bits; nothing here maps to a RAM macro.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignments so all entries
            // see the same pre-edge table regardless of statement order.
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (inc[i] && !dec[i]) begin
                    tbl[i].cnt <= tbl[i].cnt + CNT_ONE;
                    if (!tbl[i].valid) begin
                        tbl[i].valid <= 1'b1;
                        tbl[i].id    <= req_id;
                    end
                end else if (dec[i] && !inc[i]) begin
                    tbl[i].cnt <= tbl[i].cnt - CNT_ONE;
                    if (tbl[i].cnt == CNT_ONE) begin
                        tbl[i].valid <= 1'b0;
                    end
                end
            end
        end
    end

    a_rsp_known: assert property (@(posedge clk_i) disable iff (rst_i) rsp_hs |-> rsp_ok);

endmodule

// File: rtl/axi_id_remap_flat.sv
// Flat-port AXI ID remapper: squeezes wide slave IDs onto a narrow master ID
// space with separate in-flight tables for writes and reads.
module axi_id_remap_flat
    import axi_id_remap_pkg::*;
#(
    parameter int unsigned AXI_SLV_PORT_ID_WIDTH = 8,
    parameter int unsigned AXI_MST_PORT_ID_WIDTH = 3,
    parameter int unsigned AXI_MAX_UNIQ_IDS      = 4,
    parameter int unsigned AXI_MAX_TXNS_PER_ID   = 4,
    parameter int unsigned AW_PL_WIDTH           = 64,
    parameter int unsigned AR_PL_WIDTH           = 58,
    parameter int unsigned B_PL_WIDTH            = 2,
    parameter int unsigned R_PL_WIDTH            = 34,
    // Bit offset of the 6-bit atop field inside the AW payload.
    parameter int unsigned AW_ATOP_LSB           = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [AXI_SLV_PORT_ID_WIDTH-1:0] slv_aw_id_i,
    input  logic [AW_PL_WIDTH-1:0]           slv_aw_pl_i,
    input  logic                             slv_aw_valid_i,
    output logic                             slv_aw_ready_o,
    output logic [AXI_SLV_PORT_ID_WIDTH-1:0] slv_b_id_o,
    output logic [B_PL_WIDTH-1:0]            slv_b_pl_o,
    output logic                             slv_b_valid_o,
    input  logic                             slv_b_ready_i,
    input  logic [AXI_SLV_PORT_ID_WIDTH-1:0] slv_ar_id_i,
    input  logic [AR_PL_WIDTH-1:0]           slv_ar_pl_i,
    input  logic                             slv_ar_valid_i,
    output logic                             slv_ar_ready_o,
    output logic [AXI_SLV_PORT_ID_WIDTH-1:0] slv_r_id_o,
    output logic [R_PL_WIDTH-1:0]            slv_r_pl_o,
    output logic                             slv_r_last_o,
    output logic                             slv_r_valid_o,
    input  logic                             slv_r_ready_i,
    output logic [AXI_MST_PORT_ID_WIDTH-1:0] mst_aw_id_o,
    output logic [AW_PL_WIDTH-1:0]           mst_aw_pl_o,
    output logic                             mst_aw_valid_o,
    input  logic                             mst_aw_ready_i,
    input  logic [AXI_MST_PORT_ID_WIDTH-1:0] mst_b_id_i,
    input  logic [B_PL_WIDTH-1:0]            mst_b_pl_i,
    input  logic                             mst_b_valid_i,
    output logic                             mst_b_ready_o,
    output logic [AXI_MST_PORT_ID_WIDTH-1:0] mst_ar_id_o,
    output logic [AR_PL_WIDTH-1:0]           mst_ar_pl_o,
    output logic                             mst_ar_valid_o,
    input  logic                             mst_ar_ready_i,
    input  logic [AXI_MST_PORT_ID_WIDTH-1:0] mst_r_id_i,
    input  logic [R_PL_WIDTH-1:0]            mst_r_pl_i,
    input  logic                             mst_r_last_i,
    input  logic                             mst_r_valid_i,
    output logic                             mst_r_ready_o
);

    localparam int unsigned IDX_W = idx_width(AXI_MAX_UNIQ_IDS);

    if (AXI_MAX_UNIQ_IDS < 1) begin : g_bad_uniq
        $fatal(1, "AXI_MAX_UNIQ_IDS must be >= 1");
    end
    if (AXI_MAX_TXNS_PER_ID < 1) begin : g_bad_txns
        $fatal(1, "AXI_MAX_TXNS_PER_ID must be >= 1");
    end
    if (AXI_MST_PORT_ID_WIDTH < IDX_W) begin : g_bad_mst_w
        $fatal(1, "AXI_MST_PORT_ID_WIDTH too narrow for AXI_MAX_UNIQ_IDS");
    end
    if (AW_ATOP_LSB + 6 > AW_PL_WIDTH) begin : g_bad_atop
        $fatal(1, "AW_ATOP_LSB places atop outside the AW payload");
    end

    logic             aw_stall, ar_stall;
    logic             aw_hs, ar_hs, b_hs, r_last_hs;
    logic [IDX_W-1:0] aw_idx, ar_idx;

    // Reset forces every handshake signal low so nothing leaks while flushing.
    assign slv_aw_ready_o = mst_aw_ready_i & ~aw_stall & ~rst_i;
    assign mst_aw_valid_o = slv_aw_valid_i & ~aw_stall & ~rst_i;
    assign mst_aw_id_o    = AXI_MST_PORT_ID_WIDTH'(aw_idx);
    assign mst_aw_pl_o    = slv_aw_pl_i;
    assign aw_hs          = slv_aw_valid_i & slv_aw_ready_o;

    assign slv_ar_ready_o = mst_ar_ready_i & ~ar_stall & ~rst_i;
    assign mst_ar_valid_o = slv_ar_valid_i & ~ar_stall & ~rst_i;
    assign mst_ar_id_o    = AXI_MST_PORT_ID_WIDTH'(ar_idx);
    assign mst_ar_pl_o    = slv_ar_pl_i;
    assign ar_hs          = slv_ar_valid_i & slv_ar_ready_o;

    assign slv_b_valid_o  = mst_b_valid_i & ~rst_i;
    assign mst_b_ready_o  = slv_b_ready_i & ~rst_i;
    assign slv_b_pl_o     = mst_b_pl_i;
    assign b_hs           = mst_b_valid_i & mst_b_ready_o;

    assign slv_r_valid_o  = mst_r_valid_i & ~rst_i;
    assign mst_r_ready_o  = slv_r_ready_i & ~rst_i;
    assign slv_r_pl_o     = mst_r_pl_i;
    assign slv_r_last_o   = mst_r_last_i;
    assign r_last_hs      = mst_r_valid_i & mst_r_ready_o & mst_r_last_i;

    axi_id_remap_table #(
        .ID_W      (AXI_SLV_PORT_ID_WIDTH),
        .RSP_IDX_W (AXI_MST_PORT_ID_WIDTH),
        .N_ENTRIES (AXI_MAX_UNIQ_IDS),
        .MAX_TXNS  (AXI_MAX_TXNS_PER_ID)
    ) u_wr_table (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_id     (slv_aw_id_i),
        .req_hs     (aw_hs),
        .sel_idx    (aw_idx),
        .stall      (aw_stall),
        .rsp_idx    (mst_b_id_i),
        .rsp_hs     (b_hs),
        .rsp_slv_id (slv_b_id_o)
    );

    axi_id_remap_table #(
        .ID_W      (AXI_SLV_PORT_ID_WIDTH),
        .RSP_IDX_W (AXI_MST_PORT_ID_WIDTH),
        .N_ENTRIES (AXI_MAX_UNIQ_IDS),
        .MAX_TXNS  (AXI_MAX_TXNS_PER_ID)
    ) u_rd_table (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_id     (slv_ar_id_i),
        .req_hs     (ar_hs),
        .sel_idx    (ar_idx),
        .stall      (ar_stall),
        .rsp_idx    (mst_r_id_i),
        .rsp_hs     (r_last_hs),
        .rsp_slv_id (slv_r_id_o)
    );

    // Atomics that return read data would need a matching read-table entry.
    a_no_atop_r: assert property (@(posedge clk_i) disable iff (rst_i)
        slv_aw_valid_i |-> !slv_aw_pl_i[AW_ATOP_LSB + 5]);

endmodule
